// File: rtl/debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : debouncer_if
// Brief    : Level/strobe bundle between raw switch inputs and the debouncer.
// Revision : 1.0 - initial release
// ============================================================================
interface debouncer_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] noisy;
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (output noisy, input clean, input rise, input fall);
    modport slave  (input noisy, output clean, output rise, output fall);
endinterface
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
// Module   : debouncer
// Brief    : Multi-channel synchronizer + stable-level debouncer with strobes.
// Revision : 1.0 - initial release
// ============================================================================
module debouncer #(
    parameter int WIDTH       = 1,
    parameter int DELAY       = 650000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    debouncer_if.slave bus
);
    localparam int               CNT_W    = $clog2(DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

    logic [SYNC_STAGES-1:0] sync_q [WIDTH];
    logic [SYNC_STAGES-1:0] sync_d [WIDTH];
    logic [CNT_W-1:0]       cnt_q  [WIDTH];
    logic [CNT_W-1:0]       cnt_d  [WIDTH];
    logic [WIDTH-1:0]       clean_q, clean_d;
    logic [WIDTH-1:0]       rise_q, rise_d;
    logic [WIDTH-1:0]       fall_q, fall_d;
    logic [WIDTH-1:0]       sync_out;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], bus.noisy[i]};
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
            cnt_d[i]    = '0;
            clean_d[i]  = clean_q[i];
            rise_d[i]   = 1'b0;
            fall_d[i]   = 1'b0;
            // Any sample that agrees with clean leaves cnt_d at zero, so bounces never accumulate.
            if (sync_out[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = sync_out[i];
                    rise_d[i]  = sync_out[i];
                    fall_d[i]  = ~sync_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                sync_q[i] <= sync_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign bus.clean = clean_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
endmodule
`default_nettype wire

// File: tb/tb_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_debouncer
// Brief    : Random + directed check of debouncer (DELAY=4 and DELAY=1 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debouncer;
    localparam int SYNC = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] noisy = 2'b11;
    int         total = 0;
    int         bad   = 0;
    bit         cmp_on = 1'b0;

    debouncer_if #(.WIDTH(2)) if4 ();
    debouncer_if #(.WIDTH(2)) if1 ();
    assign if4.noisy = noisy;
    assign if1.noisy = noisy;

    debouncer #(.WIDTH(2), .DELAY(4), .SYNC_STAGES(SYNC)) u_dut4 (
        .clock (clock), .reset (reset), .bus (if4.slave));
    debouncer #(.WIDTH(2), .DELAY(1), .SYNC_STAGES(SYNC)) u_dut1 (
        .clock (clock), .reset (reset), .bus (if1.slave));

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: history of raw levels per edge; s at an edge is the level
    // seen SYNC edges earlier, and clean flips once the last DELAY s samples
    // all disagree with it.
    bit [7:0]  hist   [2][2];
    logic [1:0] mclean [2];
    logic [1:0] mrise  [2];
    logic [1:0] mfall  [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            mclean[d] = '0; mrise[d] = '0; mfall[d] = '0;
            hist[d][0] = '0; hist[d][1] = '0;
        end
        forever begin
            @(posedge clock or negedge reset);
            for (int d = 0; d < 2; d++) begin
                int dly;
                dly = (d == 0) ? 4 : 1;
                for (int c = 0; c < 2; c++) begin
                    if (!reset) begin
                        hist[d][c] = '0;
                        mclean[d][c] = 1'b0; mrise[d][c] = 1'b0; mfall[d][c] = 1'b0;
                    end else begin
                        bit flip;
                        hist[d][c] = {hist[d][c][6:0], noisy[c]};
                        flip = 1'b1;
                        for (int j = 0; j < dly; j++)
                            if (hist[d][c][SYNC+j] == mclean[d][c]) flip = 1'b0;
                        mrise[d][c] = 1'b0;
                        mfall[d][c] = 1'b0;
                        if (flip) begin
                            mclean[d][c] = ~mclean[d][c];
                            mrise[d][c]  = mclean[d][c];
                            mfall[d][c]  = ~mclean[d][c];
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (cmp_on) begin
                chk("dut4_crf", {26'b0, if4.clean, if4.rise, if4.fall},
                    {26'b0, mclean[0], mrise[0], mfall[0]});
                chk("dut1_crf", {26'b0, if1.clean, if1.rise, if1.fall},
                    {26'b0, mclean[1], mrise[1], mfall[1]});
            end
        end
    end

    initial begin
        int cnt;
        bit seen;

        // Reset held with inputs high across clock edges.
        repeat (2) @(negedge clock);
        chk("rst_dut4", {26'b0, if4.clean, if4.rise, if4.fall}, 32'h0);
        chk("rst_dut1", {26'b0, if1.clean, if1.rise, if1.fall}, 32'h0);
        cmp_on = 1'b1;

        // Asynchronous reset in the middle of a count.
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("pre_async_dut1_clean", {30'b0, if1.clean}, 32'h3);
        chk("pre_async_dut4_clean", {30'b0, if4.clean}, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("async_dut1", {26'b0, if1.clean, if1.rise, if1.fall}, 32'h0);
        chk("async_dut4", {26'b0, if4.clean, if4.rise, if4.fall}, 32'h0);
        noisy = 2'b00;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Clean step on channel 0.
        noisy = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (k == 5) chk("step_before", {30'b0, if4.clean}, 32'h0);
            if (k == 6) begin
                chk("step_clean", {30'b0, if4.clean}, 32'h1);
                chk("step_rise",  {30'b0, if4.rise},  32'h1);
            end
            if (k == 7) chk("step_rise_end", {30'b0, if4.rise}, 32'h0);
        end

        // Three-cycle low glitch.
        seen = 1'b0;
        noisy = 2'b00;
        repeat (3) begin @(negedge clock); seen |= if4.fall[0]; end
        noisy = 2'b01;
        repeat (10) begin @(negedge clock); seen |= if4.fall[0]; end
        chk("glitch_fall", {31'b0, seen}, 32'h0);
        chk("glitch_clean", {31'b0, if4.clean[0]}, 32'h1);

        // Bounce on channel 1, then hold high.
        cnt = 0;
        for (int b = 0; b < 4; b++) begin
            noisy[1] = ~b[0];
            repeat (2) begin @(negedge clock); cnt += int'(if4.rise[1]); end
        end
        noisy[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            cnt += int'(if4.rise[1]);
            if (k == 5) chk("bounce_before", {31'b0, if4.clean[1]}, 32'h0);
            if (k == 6) chk("bounce_clean",  {31'b0, if4.clean[1]}, 32'h1);
        end
        chk("bounce_rise_count", cnt, 32'd1);

        // Falling edge on channel 0.
        cnt = 0;
        noisy[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            cnt += int'(if4.fall[0]);
            if (k == 5) chk("fall_before", {31'b0, if4.clean[0]}, 32'h1);
            if (k == 6) begin
                chk("fall_clean", {31'b0, if4.clean[0]}, 32'h0);
                chk("fall_strobe", {30'b0, if4.fall}, 32'h1);
            end
        end
        chk("fall_count", cnt, 32'd1);

        // Simultaneous step on both channels.
        noisy = 2'b00;
        repeat (10) @(negedge clock);
        noisy = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (k == 2) chk("d1_before", {30'b0, if1.clean}, 32'h0);
            if (k == 3) begin
                chk("d1_clean", {30'b0, if1.clean}, 32'h3);
                chk("d1_rise",  {30'b0, if1.rise},  32'h3);
            end
            if (k == 5) chk("sim_before", {30'b0, if4.clean}, 32'h0);
            if (k == 6) begin
                chk("sim_clean", {30'b0, if4.clean}, 32'h3);
                chk("sim_rise",  {30'b0, if4.rise},  32'h3);
            end
        end

        // Random levels with short and long runs, plus one async reset.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clock);
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 7) == 0) noisy[c] = ~noisy[c];
            if (n == 700) begin
                #3 reset = 1'b0;
                @(negedge clock);
                @(negedge clock);
                reset = 1'b1;
            end
        end

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
